// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus launch FSM feeding a UART transmitter: one Data_Valid pulse per byte, P_DATA held for the frame.
// Optional sticky overflow flag OVF is built when TX_FEEDER_OVF_EN is defined.
module uart_tx_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  WR_EN,
  output logic                  FULL,
  output logic                  EMPTY,
  input  logic                  Busy,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  Data_Valid
`ifdef TX_FEEDER_OVF_EN
  ,
  output logic                  OVF
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic                  wr_acc, pop;
  state_t                state, state_nxt;

  // FULL is the registered flag, so a pop in the same cycle cannot rescue a write.
  assign wr_acc     = WR_EN & ~FULL;
  assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr[AW-1:0]] <= WR_DATA;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!EMPTY) begin
          pop       = 1'b1;
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (Busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!Busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FULL       <= 1'b0;
      EMPTY      <= 1'b1;
      state      <= IDLE;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      FULL       <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                    (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      EMPTY      <= (wr_ptr_nxt == rd_ptr_nxt);
      state      <= state_nxt;
      Data_Valid <= (state_nxt == LAUNCH);
      if (pop) P_DATA <= mem[rd_ptr[AW-1:0]];
    end
  end

`ifdef TX_FEEDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            OVF <= 1'b0;
    else if (WR_EN && FULL) OVF <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: queue-based reference model plus a framed Busy model.
module tb_uart_tx_feeder;
  localparam int DEPTH = 8;
  localparam int BIG   = 1 << 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       busy = 1'b0;
  logic       full, empty, dv;
  logic [7:0] p_data;
`ifdef TX_FEEDER_OVF_EN
  logic       ovf;
`endif

  always #5 clk = ~clk;

  uart_tx_feeder #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .WR_DATA    (wr_data),
    .WR_EN      (wr_en),
    .FULL       (full),
    .EMPTY      (empty),
    .Busy       (busy),
    .P_DATA     (p_data),
    .Data_Valid (dv)
`ifdef TX_FEEDER_OVF_EN
    ,
    .OVF        (ovf)
`endif
  );

  typedef struct {
    logic [7:0] d;
    int         avail;
  } ent_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  ent_t       q[$];
  int         next_ok = 0;
  int         l_edge = -100;
  int         len = 0;
  bit         active = 1'b0;
  bit         hold = 1'b0;
  logic [7:0] last = '0;
  bit         ovf_m = 1'b0;
  int         lo = 1;
  int         hi = 6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // One clock: drive inputs for edge e, then compare DUT against the model just after it.
  task automatic tick(input logic we, input logic [7:0] wd);
    int   e;
    bit   pop_e, acc;
    ent_t t;
    e = cyc + 1;
    if (!hold && next_ok == BIG) next_ok = e + 1;
    busy  = hold || (active && e >= l_edge + 2 && e <= l_edge + 1 + len);
    acc   = we && (q.size() < DEPTH);
    if (we && q.size() == DEPTH) ovf_m = 1'b1;
    pop_e = (q.size() > 0) && (q[0].avail <= e) && (e >= next_ok);
    wr_en   = we;
    wr_data = wd;
    @(posedge clk);
    #1;
    cyc = e;
    chk("data_valid", 32'(dv), 32'(pop_e));
    if (pop_e) begin
      last = q[0].d;
      void'(q.pop_front());
      l_edge  = e;
      active  = 1'b1;
      len     = int'($urandom_range(hi, lo));
      next_ok = hold ? BIG : e + len + 3;
    end
    if (acc) begin
      t.d = wd;
      t.avail = e + 1;
      q.push_back(t);
    end
    chk("p_data", 32'(p_data), 32'(last));
    chk("empty", 32'(empty), 32'(q.size() == 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
`ifdef TX_FEEDER_OVF_EN
    chk("ovf", 32'(ovf), 32'(ovf_m));
`endif
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    active = 1'b0; hold = 1'b0; next_ok = 0; last = '0; ovf_m = 1'b0;
    busy = 1'b0; wr_en = 1'b0;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dv", 32'(dv), 32'd0);
    chk("rst_p_data", 32'(p_data), 32'd0);
`ifdef TX_FEEDER_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(posedge clk); #1; cyc++;
    @(posedge clk); #1; cyc++;
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b0, 8'h00);

    // single byte, 100-cycle frame
    lo = 100; hi = 100;
    tick(1'b1, 8'hA5);
    for (int i = 0; i < 115; i++) tick(1'b0, 8'h00);

    // back-to-back burst 0x01..0x08
    lo = 2; hi = 6;
    for (int i = 1; i <= 8; i++) tick(1'b1, 8'(i));
    for (int i = 0; i < 100; i++) tick(1'b0, 8'h00);

    // Busy stuck high: ten writes, tenth must be dropped
    hold = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b1, 8'(8'h10 + i));
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00);
    chk("hold_full", 32'(full), 32'd1);
    hold = 1'b0;
    for (int i = 0; i < 120; i++) tick(1'b0, 8'h00);

    // write lands on the same edge as a launch pop with 3 queued
    hold = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1, 8'(8'h41 + i));
    for (int i = 0; i < 4; i++) tick(1'b0, 8'h00);
    hold = 1'b0;
    tick(1'b0, 8'h00);
    tick(1'b1, 8'h45);
    chk("simul_pop_byte", 32'(p_data), 32'h42);
    for (int i = 0; i < 80; i++) tick(1'b0, 8'h00);

    // random traffic with random frame lengths
    lo = 1; hi = 8;
    for (int i = 0; i < 400; i++) tick(($urandom_range(2, 0) == 0), 8'($urandom));
    for (int i = 0; i < 150; i++) tick(1'b0, 8'h00);

    // reset in the middle of a frame with 4 queued
    hold = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b1, 8'(8'h70 + i));
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00);
    do_reset();
    for (int i = 0; i < 5; i++) tick(1'b0, 8'h00);
    tick(1'b1, 8'h3C);
    for (int i = 0; i < 12; i++) tick(1'b0, 8'h00);
    chk("post_rst_byte", 32'(p_data), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
